vga_scan_timer: RTL and testbench

- Upstream stage of vga_processor. Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Produces the linear pixel address `cur_address` that vga_processor decodes to x/y, plus sync/blank outputs to the DAC, delayed to match the memory/palette pipeline.
- Also owns the game-time seconds counter that vga_processor renders as MM:SS.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_scan_timer_if.sv | 11 +
 rtl/game_timer.sv | 49 ++++
 rtl/vga_scan_timer.sv | 141 ++++++++++++++
 tb/tb_vga_scan_timer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry for the scan timer and vga_processor, plus the bundle
// of sync levels that travels down the DAC delay line.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE  = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // First address past the frame buffer; glyph ROM is mapped from here up.
  localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W    = 19;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
  } dac_sync_t;

  localparam dac_sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_scan_timer_if.sv
// DAC-side signal bundle: the timer drives it, the video DAC consumes it.
interface vga_scan_timer_if;
  logic vga_clk;
  logic vga_hs;
  logic vga_vs;
  logic vga_blank_n;
  logic vga_sync_n;

  modport master (output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n);
  modport slave  (input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n);
endinterface

// File: rtl/game_timer.sv
// Game-time seconds counter: a tick prescaler feeding a saturating seconds count.
// Runs every clock, independent of the pixel enable.
module game_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MAX_SECONDS   = 5999
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic        clear_time,
  output logic [15:0] seconds
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [15:0]       SEC_MAX   = 16'(MAX_SECONDS);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [15:0]       seconds_q, seconds_d;

  always_comb begin
    tick_d    = tick_q;
    seconds_d = seconds_q;
    if (clear_time) begin
      tick_d    = '0;
      seconds_d = '0;
    end else if (run) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (seconds_q != SEC_MAX) seconds_d = seconds_q + 16'd1;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_q    <= '0;
      seconds_q <= '0;
    end else begin
      tick_q    <= tick_d;
      seconds_q <= seconds_d;
    end
  end

  assign seconds = seconds_q;

endmodule

// File: rtl/vga_scan_timer.sv
// 640x480@60 VGA scan timer: pixel enable, h/v counters, incremental pixel
// address, pipeline-matched sync/blank to the DAC, and the game seconds counter.
module vga_scan_timer #(
  parameter int H_ACTIVE      = vga_pkg::H_ACTIVE,
  parameter int H_FP          = vga_pkg::H_FP,
  parameter int H_SYNC        = vga_pkg::H_SYNC,
  parameter int H_BP          = vga_pkg::H_BP,
  parameter int V_ACTIVE      = vga_pkg::V_ACTIVE,
  parameter int V_FP          = vga_pkg::V_FP,
  parameter int V_SYNC        = vga_pkg::V_SYNC,
  parameter int V_BP          = vga_pkg::V_BP,
  parameter int PIPE_DLY      = 2,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int MAX_SECONDS   = 5999
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
  input  logic        clear_time,
  output logic [18:0] cur_address,
  output logic        active,
  output logic        frame_start,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [15:0] seconds
);
  import vga_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int DEPTH = (PIPE_DLY > 0) ? PIPE_DLY : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic              pix_en_q, pix_en_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              active_q, active_d;
  dac_sync_t         sync_raw;
  dac_sync_t         pipe_q [DEPTH];
  dac_sync_t         pipe_d [DEPTH];

  // NOTE: every variable gets its hold value before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    pix_en_d = ~pix_en_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    addr_d   = addr_q;
    active_d = active_q;
    if (pix_en_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
      // active/addr describe the position being entered, so they line up with hcnt/vcnt.
      active_d = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
      if (hcnt_d == '0 && vcnt_d == '0) addr_d = '0;
      else if (active_d)                addr_d = addr_q + ADDR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en_q <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      addr_q   <= '0;
      active_q <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      addr_q   <= addr_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    sync_raw.hs_n    = !((hcnt_q >= HS_START) && (hcnt_q <= HS_END));
    sync_raw.vs_n    = !((vcnt_q >= VS_START) && (vcnt_q <= VS_END));
    sync_raw.blank_n = active_q;
  end

  // Shift register matching the address->index->colour latency downstream.
  always_comb begin
    pipe_d = pipe_q;
    if (pix_en_q) begin
      pipe_d[0] = sync_raw;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: the delay line is small and feeds the DAC directly, so it is reset
  // stage by stage; idle sync levels must reach the pins straight out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= SYNC_IDLE;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  game_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .MAX_SECONDS   (MAX_SECONDS)
  ) u_game_timer (
    .clock      (clock),
    .resetn     (resetn),
    .run        (run),
    .clear_time (clear_time),
    .seconds    (seconds)
  );

  assign cur_address = active_q ? addr_q : '0;
  assign active      = active_q;
  assign frame_start = pix_en_q && (hcnt_q == '0) && (vcnt_q == '0);
  assign vga_clk     = pix_en_q;
  assign vga_hs      = pipe_q[DEPTH-1].hs_n;
  assign vga_vs      = pipe_q[DEPTH-1].vs_n;
  assign vga_blank_n = pipe_q[DEPTH-1].blank_n;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Directed bench: full-geometry instance for line/address/seconds timing, and a
// shrunken-geometry instance so whole frames and saturation fit a short run.
module tb_vga_scan_timer;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic run_a = 1'b0, clear_a = 1'b0;
  logic run_b = 1'b0, clear_b = 1'b0;

  logic [18:0] cur_a, cur_b;
  logic        active_a, active_b, fs_a, fs_b;
  logic [15:0] sec_a, sec_b;

  int checks = 0;
  int errors = 0;

  vga_scan_timer_if dac_a ();
  vga_scan_timer_if dac_b ();

  always #10 clock = ~clock;

  vga_scan_timer #(.TICKS_PER_SEC(10)) u_full (
    .clock       (clock),
    .resetn      (resetn),
    .run         (run_a),
    .clear_time  (clear_a),
    .cur_address (cur_a),
    .active      (active_a),
    .frame_start (fs_a),
    .vga_clk     (dac_a.vga_clk),
    .vga_hs      (dac_a.vga_hs),
    .vga_vs      (dac_a.vga_vs),
    .vga_blank_n (dac_a.vga_blank_n),
    .vga_sync_n  (dac_a.vga_sync_n),
    .seconds     (sec_a)
  );

  // 8x4 visible, 16x8 total: frame = 2*16*8 = 256 clocks, vs low 2 lines = 64 clocks.
  vga_scan_timer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .TICKS_PER_SEC(2), .MAX_SECONDS(5999)
  ) u_small (
    .clock       (clock),
    .resetn      (resetn),
    .run         (run_b),
    .clear_time  (clear_b),
    .cur_address (cur_b),
    .active      (active_b),
    .frame_start (fs_b),
    .vga_clk     (dac_b.vga_clk),
    .vga_hs      (dac_b.vga_hs),
    .vga_vs      (dac_b.vga_vs),
    .vga_blank_n (dac_b.vga_blank_n),
    .vga_sync_n  (dac_b.vga_sync_n),
    .seconds     (sec_b)
  );

  // Releases reset on a negedge; afterwards "edge k" = k posedges since release.
  // After edge 2m the counters sit at pixel m.
  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (dac_a.vga_hs !== 1'b1) begin errors++; $display("FAIL reset_hs got %b want 1", dac_a.vga_hs); end
    checks++; if (dac_a.vga_vs !== 1'b1) begin errors++; $display("FAIL reset_vs got %b want 1", dac_a.vga_vs); end
    checks++; if (dac_a.vga_blank_n !== 1'b0) begin errors++; $display("FAIL reset_blank_n got %b want 0", dac_a.vga_blank_n); end
    checks++; if (cur_a !== 19'd0) begin errors++; $display("FAIL reset_cur_address got %0d want 0", cur_a); end
    checks++; if (active_a !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active_a); end
    checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", fs_a); end
    checks++; if (sec_a !== 16'd0) begin errors++; $display("FAIL reset_seconds got %0d want 0", sec_a); end
    checks++; if (dac_a.vga_clk !== 1'b0) begin errors++; $display("FAIL reset_vga_clk got %b want 0", dac_a.vga_clk); end
    checks++; if (dac_a.vga_sync_n !== 1'b0) begin errors++; $display("FAIL reset_sync_n got %b want 0", dac_a.vga_sync_n); end
    resetn = 1'b1;
    checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL release_fs_edge0 got %b want 0", fs_a); end
    @(negedge clock);
    checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL release_fs_edge1 got %b want 1", fs_a); end
    checks++; if (dac_a.vga_clk !== 1'b1) begin errors++; $display("FAIL release_vga_clk got %b want 1", dac_a.vga_clk); end
    @(negedge clock);
    checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL release_fs_edge2 got %b want 0", fs_a); end
  endtask

  task automatic test_address();
    do_reset();
    repeat (1278) @(negedge clock);  // (639,0)
    checks++; if (cur_a !== 19'd639) begin errors++; $display("FAIL addr_639_0 got %0d want 639", cur_a); end
    checks++; if (active_a !== 1'b1) begin errors++; $display("FAIL active_639_0 got %b want 1", active_a); end
    repeat (2) @(negedge clock);     // (640,0)
    checks++; if (cur_a !== 19'd0) begin errors++; $display("FAIL addr_640_0 got %0d want 0", cur_a); end
    checks++; if (active_a !== 1'b0) begin errors++; $display("FAIL active_640_0 got %b want 0", active_a); end
    repeat (3) @(negedge clock);     // edge 1283: blank still reflects pixel 639
    checks++; if (dac_a.vga_blank_n !== 1'b1) begin errors++; $display("FAIL blank_edge1283 got %b want 1", dac_a.vga_blank_n); end
    @(negedge clock);                // edge 1284: pixel 640 reaches the DAC
    checks++; if (dac_a.vga_blank_n !== 1'b0) begin errors++; $display("FAIL blank_edge1284 got %b want 0", dac_a.vga_blank_n); end
    repeat (316) @(negedge clock);   // edge 1600: (0,1)
    checks++; if (cur_a !== 19'd640) begin errors++; $display("FAIL addr_0_1 got %0d want 640", cur_a); end
    repeat (1278) @(negedge clock);  // (639,1)
    checks++; if (cur_a !== 19'd1279) begin errors++; $display("FAIL addr_639_1 got %0d want 1279", cur_a); end
  endtask

  task automatic test_line_timing();
    int low_cnt;
    do_reset();
    repeat (1315) @(negedge clock);
    checks++; if (dac_a.vga_hs !== 1'b1) begin errors++; $display("FAIL hs_before_fall got %b want 1", dac_a.vga_hs); end
    @(negedge clock);                // hcnt hit 656 at edge 1312, +4 clocks of delay
    checks++; if (dac_a.vga_hs !== 1'b0) begin errors++; $display("FAIL hs_fall_edge got %b want 0", dac_a.vga_hs); end
    low_cnt = 0;
    for (int i = 0; i < 1600; i++) begin
      if (dac_a.vga_hs === 1'b0) low_cnt++;
      @(negedge clock);
    end
    checks++; if (low_cnt != 192) begin errors++; $display("FAIL hs_low_width got %0d want 192", low_cnt); end
  endtask

  task automatic test_small_frame();
    int edge_n, gap, vs_low, max_addr;
    do_reset();
    edge_n = 0;
    while (fs_b !== 1'b1 && edge_n < 8) begin
      @(negedge clock);
      edge_n++;
    end
    checks++; if (edge_n != 1) begin errors++; $display("FAIL small_first_fs got edge %0d want 1", edge_n); end
    gap = 0; vs_low = 0; max_addr = 0;
    do begin
      @(negedge clock);
      gap++;
      edge_n++;
      if (dac_b.vga_vs === 1'b0) vs_low++;
      if (int'(cur_b) > max_addr) max_addr = int'(cur_b);
      if (edge_n == 14) begin  // (7,0)
        checks++; if (cur_b !== 19'd7) begin errors++; $display("FAIL small_addr_7_0 got %0d want 7", cur_b); end
      end
      if (edge_n == 18) begin  // (9,0) blanking
        checks++; if (cur_b !== 19'd0) begin errors++; $display("FAIL small_addr_9_0 got %0d want 0", cur_b); end
      end
      if (edge_n == 32) begin  // (0,1)
        checks++; if (cur_b !== 19'd8) begin errors++; $display("FAIL small_addr_0_1 got %0d want 8", cur_b); end
      end
      if (edge_n == 110) begin // (7,3)
        checks++; if (cur_b !== 19'd31) begin errors++; $display("FAIL small_addr_7_3 got %0d want 31", cur_b); end
      end
    end while (fs_b !== 1'b1 && gap < 400);
    checks++; if (gap != 256) begin errors++; $display("FAIL small_frame_period got %0d want 256", gap); end
    checks++; if (vs_low != 64) begin errors++; $display("FAIL small_vs_low got %0d want 64", vs_low); end
    checks++; if (max_addr != 31) begin errors++; $display("FAIL small_max_addr got %0d want 31", max_addr); end
  endtask

  task automatic test_seconds_pause();
    do_reset();
    run_a = 1'b1;
    repeat (35) @(negedge clock);
    run_a = 1'b0;
    checks++; if (sec_a !== 16'd3) begin errors++; $display("FAIL sec_after_35 got %0d want 3", sec_a); end
    repeat (20) @(negedge clock);
    checks++; if (sec_a !== 16'd3) begin errors++; $display("FAIL sec_paused got %0d want 3", sec_a); end
    run_a = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (sec_a !== 16'd3) begin errors++; $display("FAIL sec_resume_4 got %0d want 3", sec_a); end
    @(negedge clock);
    run_a = 1'b0;
    checks++; if (sec_a !== 16'd4) begin errors++; $display("FAIL sec_resume_5 got %0d want 4", sec_a); end
  endtask

  task automatic test_saturation();
    run_b = 1'b1;
    clear_b = 1'b1;
    @(negedge clock);
    clear_b = 1'b0;
    checks++; if (sec_b !== 16'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", sec_b); end
    repeat (11996) @(negedge clock);
    checks++; if (sec_b !== 16'd5998) begin errors++; $display("FAIL sat_preload got %0d want 5998", sec_b); end
    repeat (20) @(negedge clock);
    checks++; if (sec_b !== 16'd5999) begin errors++; $display("FAIL sat_hold got %0d want 5999", sec_b); end
    clear_b = 1'b1;
    @(negedge clock);
    clear_b = 1'b0;
    run_b = 1'b0;
    checks++; if (sec_b !== 16'd0) begin errors++; $display("FAIL sat_clear_priority got %0d want 0", sec_b); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    repeat (501) @(negedge clock);   // pixel 250 of line 0
    checks++; if (cur_a !== 19'd250) begin errors++; $display("FAIL mid_addr_250 got %0d want 250", cur_a); end
    resetn = 1'b0;
    #1;
    checks++; if (cur_a !== 19'd0) begin errors++; $display("FAIL mid_rst_addr got %0d want 0", cur_a); end
    checks++; if (active_a !== 1'b0) begin errors++; $display("FAIL mid_rst_active got %b want 0", active_a); end
    checks++; if (dac_a.vga_blank_n !== 1'b0) begin errors++; $display("FAIL mid_rst_blank got %b want 0", dac_a.vga_blank_n); end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL mid_rst_first_fs got %b want 1", fs_a); end
  endtask

  initial begin
    test_reset();
    test_address();
    test_line_timing();
    test_small_frame();
    test_seconds_pause();
    test_saturation();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
